// File: rtl/lpif_dstrm_flit_feeder.sv
// rtl/lpif_dstrm_flit_feeder.sv - LPIF transmit beat feeder: handshake, beat FIFO, CRC-8, registered dstrm bundle
// The FIFO and the CRC are separate helpers so that the top holds only the handshake and output staging.

module lpif_crc8 #(
  parameter int          W    = 256,
  parameter logic [7:0]  POLY = 8'h07
) (
  input  logic [W-1:0] data_i,
  output logic [7:0]   crc_o
);

  logic [7:0] crc_v;
  logic       fb;

  // MSB-first serial CRC, init 0, no reflection, no final XOR.
  always_comb begin
    crc_v = 8'h00;
    fb    = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb    = crc_v[7] ^ data_i[i];
      crc_v = {crc_v[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    crc_o = crc_v;
  end

endmodule

module lpif_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 258,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

module lpif_dstrm_flit_feeder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CRC_POLY   = 8'h07
) (
  input  logic                            clk_wr,
  input  logic                            rst_wr,
  input  logic                            tx_online,
  input  logic                            dstrm_stall,
  input  logic                            lp_irdy,
  input  logic                            lp_valid,
  input  logic [255:0]                    lp_data,
  input  logic [1:0]                      lp_protid,
  input  logic [3:0]                      lp_state_req,
  output logic                            pl_trdy,
  output logic [3:0]                      dstrm_state,
  output logic [1:0]                      dstrm_protid,
  output logic [255:0]                    dstrm_data,
  output logic                            dstrm_dvalid,
  output logic [7:0]                      dstrm_crc,
  output logic                            dstrm_crc_valid,
  output logic                            dstrm_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            err_irdy_drop
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]  count;
  logic [257:0]   head;
  logic [7:0]     head_crc;
  logic           push, pop;

  logic           valid_q, valid_d;
  logic [3:0]     state_q, state_d;
  logic [1:0]     protid_q, protid_d;
  logic [255:0]   data_q, data_d;
  logic           dvalid_q, dvalid_d;
  logic [7:0]     crc_q, crc_d;
  logic           irdy_blk_q, irdy_blk_d;
  logic           err_q, err_d;

  // Reset gates trdy so the link layer never sees an accept while the block is held.
  assign pl_trdy = !rst_wr && tx_online && (count < CW'(FIFO_DEPTH));
  assign push    = lp_irdy && pl_trdy && lp_valid;
  assign pop     = tx_online && !dstrm_stall && (count != '0);

  lpif_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (258),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_wr),
    .rst_i   (rst_wr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({lp_protid, lp_data}),
    .rdata_o (head),
    .count_o (count)
  );

  lpif_crc8 #(
    .W    (256),
    .POLY (CRC_POLY)
  ) u_crc (
    .data_i (head[255:0]),
    .crc_o  (head_crc)
  );

  always_comb begin
    valid_d    = tx_online;
    state_d    = tx_online ? lp_state_req : 4'h0;
    protid_d   = protid_q;
    data_d     = '0;
    dvalid_d   = 1'b0;
    crc_d      = 8'h00;
    irdy_blk_d = lp_irdy && !pl_trdy;
    err_d      = err_q || (irdy_blk_q && !lp_irdy);
    if (pop) begin
      protid_d = head[257:256];
      data_d   = head[255:0];
      dvalid_d = 1'b1;
      crc_d    = head_crc;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      valid_q    <= 1'b0;
      state_q    <= 4'h0;
      protid_q   <= 2'b00;
      data_q     <= '0;
      dvalid_q   <= 1'b0;
      crc_q      <= 8'h00;
      irdy_blk_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      state_q    <= state_d;
      protid_q   <= protid_d;
      data_q     <= data_d;
      dvalid_q   <= dvalid_d;
      crc_q      <= crc_d;
      irdy_blk_q <= irdy_blk_d;
      err_q      <= err_d;
    end
  end

  assign dstrm_valid     = valid_q;
  assign dstrm_state     = state_q;
  assign dstrm_protid    = protid_q;
  assign dstrm_data      = data_q;
  assign dstrm_dvalid    = dvalid_q;
  assign dstrm_crc       = crc_q;
  assign dstrm_crc_valid = dvalid_q;
  assign fifo_level      = count;
  assign err_irdy_drop   = err_q;

endmodule

// File: tb/tb_lpif_dstrm_flit_feeder.sv
// tb/tb_lpif_dstrm_flit_feeder.sv - directed vector bench for lpif_dstrm_flit_feeder

module tb_lpif_dstrm_flit_feeder;

  typedef struct {
    logic         on, st, ir, vl;
    logic [255:0] d;
    logic [1:0]   p;
    logic [3:0]   sr;
    logic         e_trdy, e_valid, e_dvalid;
    logic [255:0] e_data;
    logic [1:0]   e_pid;
    logic [7:0]   e_crc;
    logic [3:0]   e_state;
    logic [2:0]   e_lvl;
    logic         e_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_wr = 1'b1;
  logic         tx_online = 1'b1;
  logic         dstrm_stall = 1'b0;
  logic         lp_irdy = 1'b0;
  logic         lp_valid = 1'b0;
  logic [255:0] lp_data = '0;
  logic [1:0]   lp_protid = 2'b00;
  logic [3:0]   lp_state_req = 4'h0;
  logic         pl_trdy;
  logic [3:0]   dstrm_state;
  logic [1:0]   dstrm_protid;
  logic [255:0] dstrm_data;
  logic         dstrm_dvalid;
  logic [7:0]   dstrm_crc;
  logic         dstrm_crc_valid;
  logic         dstrm_valid;
  logic [2:0]   fifo_level;
  logic         err_irdy_drop;

  int passed = 0;
  int total  = 0;

  // CRC-8/0x07 of a lone byte 0..7 (leading zero bits leave the register at 0).
  logic [7:0] ctab [8];
  vec_t       tbl [19];

  lpif_dstrm_flit_feeder #(.FIFO_DEPTH(4), .CRC_POLY(8'h07)) dut (
    .clk_wr          (clk),
    .rst_wr          (rst_wr),
    .tx_online       (tx_online),
    .dstrm_stall     (dstrm_stall),
    .lp_irdy         (lp_irdy),
    .lp_valid        (lp_valid),
    .lp_data         (lp_data),
    .lp_protid       (lp_protid),
    .lp_state_req    (lp_state_req),
    .pl_trdy         (pl_trdy),
    .dstrm_state     (dstrm_state),
    .dstrm_protid    (dstrm_protid),
    .dstrm_data      (dstrm_data),
    .dstrm_dvalid    (dstrm_dvalid),
    .dstrm_crc       (dstrm_crc),
    .dstrm_crc_valid (dstrm_crc_valid),
    .dstrm_valid     (dstrm_valid),
    .fifo_level      (fifo_level),
    .err_irdy_drop   (err_irdy_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s #%0d: got %0h, want %0h", nm, idx, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    tx_online    = v.on;
    dstrm_stall  = v.st;
    lp_irdy      = v.ir;
    lp_valid     = v.vl;
    lp_data      = v.d;
    lp_protid    = v.p;
    lp_state_req = v.sr;
    #3;
    chk("pl_trdy", idx, 256'(pl_trdy), 256'(v.e_trdy));
    @(posedge clk);
    #1;
    chk("dstrm_valid", idx, 256'(dstrm_valid), 256'(v.e_valid));
    chk("dstrm_dvalid", idx, 256'(dstrm_dvalid), 256'(v.e_dvalid));
    chk("dstrm_crc_valid", idx, 256'(dstrm_crc_valid), 256'(v.e_dvalid));
    chk("dstrm_data", idx, dstrm_data, v.e_data);
    chk("dstrm_protid", idx, 256'(dstrm_protid), 256'(v.e_pid));
    chk("dstrm_crc", idx, 256'(dstrm_crc), 256'(v.e_crc));
    chk("dstrm_state", idx, 256'(dstrm_state), 256'(v.e_state));
    chk("fifo_level", idx, 256'(fifo_level), 256'(v.e_lvl));
    chk("err_irdy_drop", idx, 256'(err_irdy_drop), 256'(v.e_err));
  endtask

  task automatic step(input logic on, input logic st, input logic ir, input logic vl,
                      input logic [255:0] d, input logic [1:0] p, input logic [3:0] sr,
                      input logic et, input logic ev, input logic edv, input logic [255:0] ed,
                      input logic [1:0] ep, input logic [7:0] ec, input logic [3:0] es,
                      input logic [2:0] el, input logic ee, input int idx);
    vec_t v;
    v = '{on, st, ir, vl, d, p, sr, et, ev, edv, ed, ep, ec, es, el, ee};
    run_vec(v, idx);
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst pl_trdy", idx, 256'(pl_trdy), 256'(0));
    chk("rst dstrm_valid", idx, 256'(dstrm_valid), 256'(0));
    chk("rst dstrm_dvalid", idx, 256'(dstrm_dvalid), 256'(0));
    chk("rst dstrm_crc_valid", idx, 256'(dstrm_crc_valid), 256'(0));
    chk("rst dstrm_data", idx, dstrm_data, 256'(0));
    chk("rst dstrm_protid", idx, 256'(dstrm_protid), 256'(0));
    chk("rst dstrm_crc", idx, 256'(dstrm_crc), 256'(0));
    chk("rst dstrm_state", idx, 256'(dstrm_state), 256'(0));
    chk("rst fifo_level", idx, 256'(fifo_level), 256'(0));
    chk("rst err_irdy_drop", idx, 256'(err_irdy_drop), 256'(0));
  endtask

  initial begin
    ctab[0] = 8'h00; ctab[1] = 8'h07; ctab[2] = 8'h0E; ctab[3] = 8'h09;
    ctab[4] = 8'h1C; ctab[5] = 8'h1B; ctab[6] = 8'h12; ctab[7] = 8'h15;

    //              on  st  ir  vl  d           p  sr  | trdy v dv data        pid crc   st  lvl err
    tbl[0]  = '{1, 0, 1, 1, 256'h1,   1, 3,  1, 1, 0, 256'h0,   0, 8'h00, 3, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 256'h0,   0, 3,  1, 1, 1, 256'h1,   1, 8'h07, 3, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 256'h0,   0, 3,  1, 1, 0, 256'h0,   1, 8'h00, 3, 0, 0};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) tbl[3] = '{1, 0, 1, 1, 256'h0, 0, 3, 1, 1, 0, 256'h0, 1, 8'h00, 3, 1, 0};
      else tbl[3+i] = '{1, 0, 1, 1, 256'(i), 2'(i), 3, 1, 1, 1, 256'(i-1), 2'(i-1), ctab[i-1], 3, 1, 0};
    end
    tbl[11] = '{1, 0, 0, 0, 256'h0,   0, 3,  1, 1, 1, 256'h7,   3, 8'h15, 3, 0, 0};
    for (int i = 12; i < 15; i++)
      tbl[i] = '{1, 0, 1, 0, 256'hFF, 0, 4'hA, 1, 1, 0, 256'h0, 3, 8'h00, 4'hA, 0, 0};
    tbl[15] = '{1, 0, 1, 1, 256'h100, 2, 3, 1, 1, 0, 256'h0,   3, 8'h00, 3, 1, 0};
    tbl[16] = '{1, 0, 0, 0, 256'h0,   0, 3,  1, 1, 1, 256'h100, 2, 8'h15, 3, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 256'h0,   0, 5,  0, 0, 0, 256'h0,   2, 8'h00, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 256'h0,   0, 3,  1, 1, 0, 256'h0,   2, 8'h00, 3, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero(0);
    rst_wr = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], i);

    // Stall with 5 beats offered into a 4-deep FIFO, then release.
    step(1,1,1,1, 256'h1, 1, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 1, 0, 100);
    step(1,1,1,1, 256'h2, 2, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 2, 0, 101);
    step(1,1,1,1, 256'h3, 3, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 3, 0, 102);
    step(1,1,1,1, 256'h4, 0, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 4, 0, 103);
    step(1,1,1,1, 256'h5, 1, 3,  0,1,0, 256'h0, 2, 8'h00, 3, 4, 0, 104);
    step(1,0,1,1, 256'h5, 1, 3,  0,1,1, 256'h1, 1, 8'h07, 3, 3, 0, 105);
    step(1,0,1,1, 256'h5, 1, 3,  1,1,1, 256'h2, 2, 8'h0E, 3, 3, 0, 106);
    step(1,0,0,0, 256'h0, 0, 3,  1,1,1, 256'h3, 3, 8'h09, 3, 2, 0, 107);
    step(1,0,0,0, 256'h0, 0, 3,  1,1,1, 256'h4, 0, 8'h1C, 3, 1, 0, 108);
    step(1,0,0,0, 256'h0, 0, 3,  1,1,1, 256'h5, 1, 8'h1B, 3, 0, 0, 109);

    // Offline with 3 entries queued, then resume draining in order.
    step(1,1,1,1, 256'h6,   0, 3,  1,1,0, 256'h0,   1, 8'h00, 3, 1, 0, 200);
    step(1,1,1,1, 256'h7,   1, 3,  1,1,0, 256'h0,   1, 8'h00, 3, 2, 0, 201);
    step(1,1,1,1, 256'h100, 2, 3,  1,1,0, 256'h0,   1, 8'h00, 3, 3, 0, 202);
    step(0,0,0,0, 256'h0,   0, 3,  0,0,0, 256'h0,   1, 8'h00, 0, 3, 0, 203);
    step(0,0,0,0, 256'h0,   0, 3,  0,0,0, 256'h0,   1, 8'h00, 0, 3, 0, 204);
    step(1,0,0,0, 256'h0,   0, 3,  1,1,1, 256'h6,   0, 8'h12, 3, 2, 0, 205);
    step(1,0,0,0, 256'h0,   0, 3,  1,1,1, 256'h7,   1, 8'h15, 3, 1, 0, 206);
    step(1,0,0,0, 256'h0,   0, 3,  1,1,1, 256'h100, 2, 8'h15, 3, 0, 0, 207);

    // Full FIFO, irdy withdrawn without trdy -> sticky error; async reset mid-drain.
    step(1,1,1,1, 256'h1, 3, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 1, 0, 300);
    step(1,1,1,1, 256'h2, 3, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 2, 0, 301);
    step(1,1,1,1, 256'h3, 3, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 3, 0, 302);
    step(1,1,1,1, 256'h4, 3, 3,  1,1,0, 256'h0, 2, 8'h00, 3, 4, 0, 303);
    step(1,1,1,1, 256'h5, 3, 3,  0,1,0, 256'h0, 2, 8'h00, 3, 4, 0, 304);
    step(1,1,0,0, 256'h0, 0, 3,  0,1,0, 256'h0, 2, 8'h00, 3, 4, 1, 305);
    step(1,0,0,0, 256'h0, 0, 3,  0,1,1, 256'h1, 3, 8'h07, 3, 3, 1, 306);
    step(1,0,0,0, 256'h0, 0, 3,  1,1,1, 256'h2, 3, 8'h0E, 3, 2, 1, 307);
    #2;
    rst_wr = 1'b1;
    #1;
    chk_all_zero(308);
    @(posedge clk);
    #1;
    rst_wr = 1'b0;
    step(1,0,0,0, 256'h0, 0, 3,  1,1,0, 256'h0, 0, 8'h00, 3, 0, 0, 309);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
